// File: rtl/mem_access_stage.sv
// MEM stage: drives a req/ack data-memory bus, extracts and extends load data, steers store lanes,
// and registers the MEM/WB result. Misaligned or illegal accesses and bus timeouts abort with an error pulse.
module mem_access_stage #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd_addr,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_memRead,
    input  logic        ex_memWrite,
    input  logic        ex_memToReg,
    input  logic        ex_regWrite,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] mem_rd_data_out,
    output logic [31:0] data_out,
    output logic [4:0]  mem_rd_addr_out,
    output logic        memToReg_out,
    output logic        regWrite_out,
    output logic        valid_out,
    output logic        mem_err,
    output logic [1:0]  err_code
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic        is_store, mem_op, f3_legal, misaligned, bad_access, busy, timeout_hit;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic        cap_valid, cap_err, cap_regwrite;
    logic [1:0]  cap_code;
    logic [31:0] cap_rdata;

    assign is_store    = ex_memWrite & ~ex_memRead;
    assign mem_op      = ex_valid & (ex_memRead | ex_memWrite);
    assign busy        = (state_reg == BUSY);
    assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT));

    // Unsigned sizes exist only for loads.
    always_comb begin
        f3_legal = 1'b0;
        case (ex_funct3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = ex_memRead;
            default:                f3_legal = 1'b0;
        endcase
    end

    assign misaligned = ((ex_funct3[1:0] == 2'b01) & ex_alu_result[0]) |
                        ((ex_funct3[1:0] == 2'b10) & (|ex_alu_result[1:0]));
    assign bad_access = ~f3_legal | misaligned;

    // Gated by rst_n so the stall also drops while reset is held.
    assign mem_stall = rst_n & mem_op & ~bad_access & ~(busy & (dmem_ack | timeout_hit));
    assign dmem_req  = busy;
    assign dmem_we   = busy & is_store;
    assign dmem_addr = {ex_alu_result[31:2], 2'b00};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = gi;
            assign dmem_wdata[8*gi +: 8] =
                (ex_funct3[1:0] == 2'b00) ? ex_store_data[7:0] :
                (ex_funct3[1:0] == 2'b01) ? ex_store_data[8*(gi%2) +: 8] :
                                            ex_store_data[8*gi +: 8];
            assign dmem_be[gi] =
                (ex_funct3[1:0] == 2'b00) ? (ex_alu_result[1:0] == LANE) :
                (ex_funct3[1:0] == 2'b01) ? (ex_alu_result[1] == LANE[1]) :
                                            1'b1;
        end
    endgenerate

    assign ld_byte = dmem_rdata[{ex_alu_result[1:0], 3'b000} +: 8];
    assign ld_half = ex_alu_result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        case (ex_funct3)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_data = {24'd0, ld_byte};
            3'b101:  load_data = {16'd0, ld_half};
            default: load_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: if (mem_op && !bad_access) begin
                state_next = BUSY;
                cnt_next   = '0;
            end
            BUSY: begin
                if (dmem_ack || timeout_hit) state_next = IDLE;
                else                         cnt_next   = cnt_reg + CNT_W'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    // Decide what, if anything, the MEM/WB registers capture at the next edge.
    always_comb begin
        cap_valid    = 1'b0;
        cap_err      = 1'b0;
        cap_code     = 2'b00;
        cap_regwrite = ex_regWrite;
        cap_rdata    = '0;
        case (state_reg)
            IDLE: if (ex_valid) begin
                if (!mem_op) begin
                    cap_valid = 1'b1;
                end else if (bad_access) begin
                    cap_valid    = 1'b1;
                    cap_err      = 1'b1;
                    cap_code     = 2'b01;
                    cap_regwrite = 1'b0;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    cap_valid = 1'b1;
                    cap_rdata = ex_memRead ? load_data : 32'd0;
                end else if (timeout_hit) begin
                    cap_valid    = 1'b1;
                    cap_err      = 1'b1;
                    cap_code     = 2'b10;
                    cap_regwrite = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd_data_out <= '0;
            data_out        <= '0;
            mem_rd_addr_out <= '0;
            memToReg_out    <= 1'b0;
            regWrite_out    <= 1'b0;
            valid_out       <= 1'b0;
            mem_err         <= 1'b0;
            err_code        <= 2'b00;
        end else begin
            valid_out <= cap_valid;
            mem_err   <= cap_err;
            err_code  <= cap_code;
            if (cap_valid) begin
                mem_rd_data_out <= cap_rdata;
                data_out        <= ex_alu_result;
                mem_rd_addr_out <= ex_rd_addr;
                memToReg_out    <= ex_memToReg;
                regWrite_out    <= cap_regwrite;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected MEM/WB results are queued when an instruction
// is driven and popped when the stage reports valid_out.
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_memRead, ex_memWrite, ex_memToReg, ex_regWrite;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [4:0]  ex_rd_addr;
    logic [2:0]  ex_funct3;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        mem_stall, memToReg_out, regWrite_out, valid_out, mem_err;
    logic [31:0] mem_rd_data_out, data_out;
    logic [4:0]  mem_rd_addr_out;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr), .ex_funct3(ex_funct3),
        .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite), .ex_memToReg(ex_memToReg),
        .ex_regWrite(ex_regWrite), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
        .mem_rd_data_out(mem_rd_data_out), .data_out(data_out),
        .mem_rd_addr_out(mem_rd_addr_out), .memToReg_out(memToReg_out),
        .regWrite_out(regWrite_out), .valid_out(valid_out), .mem_err(mem_err),
        .err_code(err_code)
    );

    typedef struct packed {
        logic [31:0] rd_data;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        m2r;
        logic        rw;
        logic        err;
        logic [1:0]  code;
    } res_t;

    res_t exp_q[$];
    res_t e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   held, stalls, reqs, wes;
    logic done;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;

    logic [2:0]  lf3   [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b010, 3'b000};
    logic [31:0] laddr [7] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h104, 32'h101};
    logic [31:0] lrd   [7] = '{32'h80FF_FFFF, 32'h80FF_FFFF, 32'h8001_0000, 32'h8001_0000,
                               32'h1234_7FFE, 32'hCAFE_BABE, 32'h0000_7F00};
    logic [31:0] lexp  [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001,
                               32'h0000_7FFE, 32'hCAFE_BABE, 32'h0000_007F};

    function automatic res_t observed();
        return {mem_rd_data_out, data_out, mem_rd_addr_out, memToReg_out, regWrite_out, mem_err, err_code};
    endfunction

    task automatic set_op(input logic rd, input logic wr, input logic m2r, input logic rw,
                          input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] rda);
        ex_valid = 1'b1; ex_memRead = rd; ex_memWrite = wr; ex_memToReg = m2r; ex_regWrite = rw;
        ex_funct3 = f3; ex_alu_result = addr; ex_store_data = sdata; ex_rd_addr = rda;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_memRead = 1'b0; ex_memWrite = 1'b0; ex_memToReg = 1'b0;
        ex_regWrite = 1'b0; ex_funct3 = 3'b000; ex_alu_result = '0; ex_store_data = '0;
        ex_rd_addr = '0;
    endtask

    task automatic pop_exp(output res_t r);
        if (exp_q.size() > 0) r = exp_q.pop_front();
        else r = '1;
    endtask

    // Holds the current instruction until the stage releases it; ack on the ack_after-th BUSY cycle.
    task automatic run_op(input int ack_after, input logic [31:0] rdata);
        int   busy_n = 0;
        logic s;
        held = 0; stalls = 0; reqs = 0; wes = 0; done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (dmem_req) begin
                busy_n++;
                dmem_ack   = (busy_n == ack_after);
                dmem_rdata = dmem_ack ? rdata : 32'hDEAD_BEEF;
            end
            #1;
            held++;
            if (mem_stall) stalls++;
            if (dmem_we) wes++;
            if (dmem_req) begin
                reqs++; cap_addr = dmem_addr; cap_wdata = dmem_wdata; cap_be = dmem_be;
            end
            s = mem_stall;
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            if (!s) done = 1'b1;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_checks++;
        if ({dmem_req, dmem_we, mem_stall, valid_out, mem_err, err_code, regWrite_out, memToReg_out,
             mem_rd_addr_out, data_out, mem_rd_data_out} === '0) n_pass++;
        else $display("FAIL reset_state: got valid=%b req=%b stall=%b res=%h, want all 0",
                      valid_out, dmem_req, mem_stall, observed());
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_alu();
        set_op(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 32'h1234, 32'h0, 5'd5);
        exp_q.push_back('{32'h0, 32'h1234, 5'd5, 1'b0, 1'b1, 1'b0, 2'b00});
        run_op(0, 32'h0);
        idle_inputs();
        pop_exp(e);
        n_checks++;
        if (done && valid_out === 1'b1 && observed() === e) n_pass++;
        else $display("FAIL alu_result: got valid=%b res=%h, want valid=1 res=%h", valid_out, observed(), e);
        n_checks++;
        if (held == 1 && stalls == 0) n_pass++;
        else $display("FAIL alu_no_stall: got held=%0d stalls=%0d, want held=1 stalls=0", held, stalls);
        @(posedge clk); #1;
        n_checks++;
        if (valid_out === 1'b0) n_pass++;
        else $display("FAIL alu_valid_pulse: got valid_out=%b, want 0", valid_out);
    endtask

    task automatic test_loads();
        for (int i = 0; i < 7; i++) begin
            set_op(1'b1, 1'b0, 1'b1, 1'b1, lf3[i], laddr[i], 32'h0, 5'(i + 10));
            exp_q.push_back('{lexp[i], laddr[i], 5'(i + 10), 1'b1, 1'b1, 1'b0, 2'b00});
            run_op(1, lrd[i]);
            idle_inputs();
            pop_exp(e);
            n_checks++;
            if (done && valid_out === 1'b1 && observed() === e) n_pass++;
            else $display("FAIL load_%0d: got valid=%b res=%h, want res=%h", i, valid_out, observed(), e);
            if (i == 0) begin
                n_checks++;
                if (held == 2 && reqs == 1 && cap_addr === 32'h100) n_pass++;
                else $display("FAIL lb_timing: got held=%0d reqs=%0d addr=%h, want 2 1 00000100",
                              held, reqs, cap_addr);
            end
        end
    endtask

    task automatic test_stores();
        set_op(1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 32'h202, 32'hABCD_1234, 5'd0);
        exp_q.push_back('{32'h0, 32'h202, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00});
        run_op(3, 32'h0);
        idle_inputs();
        pop_exp(e);
        n_checks++;
        if (done && valid_out === 1'b1 && observed() === e) n_pass++;
        else $display("FAIL sh_result: got valid=%b res=%h, want res=%h", valid_out, observed(), e);
        n_checks++;
        if (cap_addr === 32'h200 && cap_wdata === 32'h1234_1234 && cap_be === 4'b1100) n_pass++;
        else $display("FAIL sh_bus: got addr=%h wdata=%h be=%b, want 00000200 12341234 1100",
                      cap_addr, cap_wdata, cap_be);
        n_checks++;
        if (held == 4 && reqs == 3 && wes == 3) n_pass++;
        else $display("FAIL sh_timing: got held=%0d reqs=%0d wes=%0d, want 4 3 3", held, reqs, wes);
        for (int l = 0; l < 4; l++) begin
            set_op(1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 32'h10 + 32'(l), 32'h1122_3377, 5'd3);
            exp_q.push_back('{32'h0, 32'h10 + 32'(l), 5'd3, 1'b0, 1'b1, 1'b0, 2'b00});
            run_op(1, 32'h0);
            idle_inputs();
            pop_exp(e);
            n_checks++;
            if (done && valid_out === 1'b1 && observed() === e && cap_wdata === 32'h7777_7777 &&
                cap_be === (4'b0001 << l)) n_pass++;
            else $display("FAIL sb_lane_%0d: got be=%b wdata=%h res=%h, want be=%b wdata=77777777 res=%h",
                          l, cap_be, cap_wdata, observed(), 4'b0001 << l, e);
        end
    endtask

    task automatic test_misaligned();
        logic [2:0]  f3s [3] = '{3'b010, 3'b010, 3'b100};
        logic [31:0] ads [3] = '{32'h101, 32'h102, 32'h100};
        logic        rds [3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            set_op(rds[i], ~rds[i], rds[i], 1'b1, f3s[i], ads[i], 32'hFFFF_FFFF, 5'd7);
            exp_q.push_back('{32'h0, ads[i], 5'd7, rds[i], 1'b0, 1'b1, 2'b01});
            run_op(1, 32'h0);
            idle_inputs();
            pop_exp(e);
            n_checks++;
            if (done && valid_out === 1'b1 && observed() === e) n_pass++;
            else $display("FAIL bad_access_%0d: got valid=%b res=%h, want res=%h", i, valid_out, observed(), e);
            n_checks++;
            if (held == 1 && reqs == 0) n_pass++;
            else $display("FAIL bad_access_req_%0d: got held=%0d reqs=%0d, want 1 0", i, held, reqs);
        end
    endtask

    task automatic test_timeout();
        logic stray_ok = 1'b1;
        set_op(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h300, 32'h0, 5'd9);
        exp_q.push_back('{32'h0, 32'h300, 5'd9, 1'b1, 1'b0, 1'b1, 2'b10});
        run_op(-1, 32'h0);
        idle_inputs();
        pop_exp(e);
        n_checks++;
        if (done && valid_out === 1'b1 && observed() === e) n_pass++;
        else $display("FAIL timeout_result: got done=%b valid=%b res=%h, want res=%h", done, valid_out, observed(), e);
        n_checks++;
        if (held == TO + 2 && reqs == TO + 1) n_pass++;
        else $display("FAIL timeout_timing: got held=%0d reqs=%0d, want %0d %0d", held, reqs, TO + 2, TO + 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
            #1 if (dmem_req || mem_stall) stray_ok = 1'b0;
            @(posedge clk); #1;
            if (valid_out || mem_err) stray_ok = 1'b0;
        end
        dmem_ack = 1'b0;
        n_checks++;
        if (stray_ok) n_pass++;
        else $display("FAIL stray_ack: got a response to an ack in IDLE, want none");
    endtask

    task automatic test_reset_busy();
        logic pre;
        set_op(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h40, 32'h0, 5'd4);
        @(negedge clk); @(posedge clk); @(negedge clk);
        #1 pre = dmem_req;
        n_checks++;
        if (pre === 1'b1) n_pass++;
        else $display("FAIL busy_before_reset: got dmem_req=%b, want 1", pre);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({dmem_req, dmem_we, mem_stall, valid_out, mem_err, err_code, regWrite_out, data_out,
             mem_rd_addr_out, mem_rd_data_out} === '0) n_pass++;
        else $display("FAIL reset_in_busy: got req=%b stall=%b valid=%b res=%h, want all 0",
                      dmem_req, mem_stall, valid_out, observed());
        idle_inputs();
        @(posedge clk); #1 rst_n = 1'b1;
        set_op(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 32'h55AA, 32'h0, 5'd12);
        exp_q.push_back('{32'h0, 32'h55AA, 5'd12, 1'b0, 1'b1, 1'b0, 2'b00});
        run_op(0, 32'h0);
        idle_inputs();
        pop_exp(e);
        n_checks++;
        if (done && valid_out === 1'b1 && observed() === e && held == 1) n_pass++;
        else $display("FAIL alu_after_reset: got valid=%b held=%0d res=%h, want res=%h", valid_out, held, observed(), e);
    endtask

    task automatic test_back_to_back();
        set_op(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 32'hA0A0, 32'h0, 5'd1);
        exp_q.push_back('{32'h0, 32'hA0A0, 5'd1, 1'b0, 1'b1, 1'b0, 2'b00});
        run_op(0, 32'h0);
        pop_exp(e);
        n_checks++;
        if (done && valid_out === 1'b1 && observed() === e) n_pass++;
        else $display("FAIL b2b_first: got valid=%b res=%h, want res=%h", valid_out, observed(), e);
        set_op(1'b1, 1'b0, 1'b1, 1'b1, 3'b101, 32'h402, 32'h0, 5'd2);
        exp_q.push_back('{32'h0000_C001, 32'h402, 5'd2, 1'b1, 1'b1, 1'b0, 2'b00});
        run_op(2, 32'hC001_0000);
        pop_exp(e);
        n_checks++;
        if (done && valid_out === 1'b1 && observed() === e) n_pass++;
        else $display("FAIL b2b_lhu: got valid=%b res=%h, want res=%h", valid_out, observed(), e);
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'hB0B0, 32'h0, 5'd3);
        exp_q.push_back('{32'h0, 32'hB0B0, 5'd3, 1'b0, 1'b0, 1'b0, 2'b00});
        run_op(0, 32'h0);
        idle_inputs();
        pop_exp(e);
        n_checks++;
        if (done && valid_out === 1'b1 && observed() === e && exp_q.size() == 0) n_pass++;
        else $display("FAIL b2b_last: got valid=%b res=%h left=%0d, want res=%h left=0",
                      valid_out, observed(), exp_q.size(), e);
    endtask

    initial begin
        idle_inputs();
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        rst_n      = 1'b1;
        test_reset();
        test_alu();
        test_loads();
        test_stores();
        test_misaligned();
        test_timeout();
        test_reset_busy();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
